// File: rtl/return_stack_pkg.sv
// return_stack_pkg: shared types for the hardware return-address stack.
// Holds the full-stack policy enum that the PC and any other stack user
// import, plus the decoded per-cycle operation type used by return_stack.
package return_stack_pkg;

  // Full-stack policy: RS_WRAP overwrites the oldest entry, RS_SAT drops the push.
  typedef enum logic {
    RS_WRAP = 1'b0,
    RS_SAT  = 1'b1
  } rs_ovf_mode_e;

  // One operation per cycle, already resolved by priority.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_REPLACE,   // push and pop together on a non-empty stack
    OP_PUSH,
    OP_POP
  } rs_op_e;

  // True when n is a power of two and at least 2.
  function automatic bit rs_depth_ok(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/return_stack.sv
// return_stack: single-cycle hardware return-address stack.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   advance; when low every other control input is ignored
//   push      in   push data_in
//   pop       in   pop the top entry
//   flush     in   discard all entries (highest priority)
//   err_clr   in   clear the sticky error flags
//   data_in   in   value to push
//   top       out  registered top-of-stack value (0 while empty)
//   count     out  number of valid entries
//   empty     out  count == 0
//   full      out  count == DEPTH
//   ovf_err   out  sticky: push while full
//   unf_err   out  sticky: pop while empty
//
// The array is a plain register file indexed by a pointer that wraps modulo
// DEPTH. top is a separate register loaded with the value the next pointer
// will sit above, so no output has a combinational path from any input.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int           DATA_W   = 32,
  parameter int           DEPTH    = 16,
  parameter rs_ovf_mode_e OVF_MODE = RS_WRAP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       err_clr,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (!rs_depth_ok(DEPTH)) begin : g_bad_depth
    $error("return_stack: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic              ovf_evt, unf_evt;
  logic              empty_w, full_w;
  rs_op_e            op;

  assign empty_w = (cnt_q == '0);
  assign full_w  = (cnt_q == CNT_W'(DEPTH));

  // Priority: flush > push&pop > push > pop > idle. Push and pop together
  // on an empty stack falls through to a plain push.
  always_comb begin
    op = OP_IDLE;
    if (en) begin
      if (flush)                   op = OP_FLUSH;
      else if (push && pop && !empty_w) op = OP_REPLACE;
      else if (push)               op = OP_PUSH;
      else if (pop)                op = OP_POP;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    mem_we    = 1'b0;
    mem_waddr = sp_q;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    unique case (op)
      OP_FLUSH: begin
        sp_d  = '0;
        cnt_d = '0;
        top_d = '0;
      end
      OP_REPLACE: begin
        mem_we    = 1'b1;
        mem_waddr = sp_q - PTR_W'(1);
        top_d     = data_in;
      end
      OP_PUSH: begin
        if (!full_w) begin
          mem_we = 1'b1;
          sp_d   = sp_q + PTR_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
          top_d  = data_in;
        end else begin
          ovf_evt = 1'b1;
          // Wrapping overwrites the oldest slot, which is the one at the pointer.
          if (OVF_MODE == RS_WRAP) begin
            mem_we = 1'b1;
            sp_d   = sp_q + PTR_W'(1);
            top_d  = data_in;
          end
        end
      end
      OP_POP: begin
        if (!empty_w) begin
          sp_d  = sp_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
          // The new top sits two below the current pointer; an emptied stack
          // shows 0 so stale array contents never leak out.
          top_d = (cnt_q == CNT_W'(1)) ? '0 : mem_q[sp_q - PTR_W'(2)];
        end else begin
          unf_evt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A same-cycle error event wins over err_clr.
  assign ovf_d = ovf_evt | (ovf_q & ~(en & err_clr));
  assign unf_d = unf_evt | (unf_q & ~(en & err_clr));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: the array has no reset; its contents are only ever visible through
  // top, which is forced to 0 whenever the stack is empty.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem_q[mem_waddr] <= data_in;
  end

  assign top     = top_q;
  assign count   = cnt_q;
  assign empty   = empty_w;
  assign full    = full_w;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DATA_W, default 32, width of each stacked return address.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two and at least 2 (elaboration error otherwise).
REQ-003 Parameter OVF_MODE, default RS_WRAP, full-stack policy: RS_WRAP overwrites the oldest entry, RS_SAT drops the push.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  pipeline advance; when 0, all state holds and push, pop, flush and err_clr are ignored.
REQ-007 push  in  1  push data_in.
REQ-008 pop  in  1  pop top entry.
REQ-009 flush  in  1  discard all entries.
REQ-010 err_clr  in  1  clear sticky error flags.
REQ-011 data_in  in  DATA_W  value to push.
REQ-012 top  out  DATA_W  registered top-of-stack value.
REQ-013 count  out  $clog2(DEPTH+1)  number of valid entries.
REQ-014 empty  out  1  count==0.
REQ-015 full  out  1  count==DEPTH.
REQ-016 ovf_err  out  1  sticky; set when a push occurs while full.
REQ-017 unf_err  out  1  sticky; set when a pop occurs while empty.

Function
REQ-018 Storage SHALL be a DEPTH-entry register array addressed by a log2(DEPTH)-bit stack pointer that wraps modulo DEPTH.
REQ-019 Operation priority when en=1: flush > push&pop > push > pop > idle.
REQ-020 Flush: count becomes 0, top becomes 0, and flush overrides push and pop; error flags are unaffected unless err_clr is also asserted.
REQ-021 Push with count<DEPTH: write data_in at the pointer, increment the pointer and count, and top SHALL equal data_in in the next cycle.
REQ-022 Push with count==DEPTH, RS_WRAP: write data_in, advance the pointer over the oldest entry, keep count at DEPTH, update top, and set ovf_err.
REQ-023 Push with count==DEPTH, RS_SAT: leave the array, pointer, count and top unchanged, and set ovf_err.
REQ-024 Pop with count>0: decrement the pointer and count; top SHALL become the new top entry next cycle, or 0 if the stack becomes empty.
REQ-025 Pop with count==0: change no state except setting unf_err.
REQ-026 Push and pop together with count>0: replace the top entry with data_in, keep count unchanged, and update top; this raises no error.
REQ-027 Push and pop together with count==0: behave as a plain push (count becomes 1) and raise no error.
REQ-028 top SHALL always reflect the entry below the pointer and stay consistent across wrap-around of the pointer.
REQ-029 err_clr clears ovf_err and unf_err; an error event in the same cycle wins (the flag stays set).
REQ-030 empty and full are derived combinationally from registered count; the block has no combinational path from any input to any output.
REQ-031 Every operation completes in a single cycle with one-cycle visibility on top and count; no back-pressure exists.

Reset
REQ-032 On rst_n low, asynchronously: pointer=0, count=0, top=0, ovf_err=0, unf_err=0; therefore empty=1 and full=0.
REQ-033 Array contents are not reset and SHALL never be observable through top while empty.
REQ-034 Reset asserted mid-operation aborts that operation; the first edge after release behaves as from a fresh reset.

Structure
REQ-035 Package return_stack_pkg holds enum rs_ovf_mode_e {RS_WRAP, RS_SAT}; the PC and any future stack users import it.
REQ-036 The block is a single module with no sub-modules; the array is inferred as logic, not RAM, so that top can be registered from the next pointer.

Verification
REQ-037 Reset, then push 0x100, 0x200, 0x300 -> top=0x300, count=3; then pop, pop -> top=0x100, count=1.
REQ-038 DEPTH=4, RS_WRAP: push 1..5 -> count=4, full=1, ovf_err=1, top=5; four pops then yield tops 4, 3, 2, then 0 with empty=1 (entry 1 is lost).
REQ-039 DEPTH=4, RS_SAT: push 1..5 -> top=4, ovf_err=1; a fifth pop -> unf_err=1, count=0; err_clr -> both error flags 0.
REQ-040 Push 0xA, then push and pop together with 0xB -> count=1, top=0xB, no error; same stimulus with en=0 -> no change.
REQ-041 Push 3 entries, then flush together with push 0xF -> count=0, top=0; asserting rst_n low mid-sequence -> all outputs return to reset values immediately.
